// File: rtl/rr_lock_arbiter_pkg.sv
// Shared types for the round-robin lock arbiter: FSM state encoding and legal
// requester-count bounds.
package rr_lock_arbiter_pkg;

  localparam int MinNumReq = 2;
  localparam int MaxNumReq = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

endpackage

// File: rtl/rr_lock_arbiter_pick.sv
// rr_pick: combinational find-first-set over (req & mask), searching upward
// from ptr and wrapping to 0; returns one-hot, binary index and a found flag.
module rr_pick #(
  parameter int NumReq = 4,
  parameter int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [NumReq-1:0] mask_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] onehot_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              found_o
);

  logic [NumReq-1:0] cand;

  assign cand = req_i & mask_i;

  always_comb begin
    logic hit;
    hit      = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    // First pass covers [ptr, NumReq-1], second pass the wrapped part [0, ptr-1].
    for (int i = 0; i < NumReq; i++) begin
      if (!hit && cand[i] && (i >= int'(ptr_i))) begin
        hit         = 1'b1;
        idx_o       = IdxW'(i);
        onehot_o[i] = 1'b1;
      end
    end
    for (int i = 0; i < NumReq; i++) begin
      if (!hit && cand[i]) begin
        hit         = 1'b1;
        idx_o       = IdxW'(i);
        onehot_o[i] = 1'b1;
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with per-owner lock and registered one-hot grant.
// Lock support is compiled in only when RR_LOCK_ARBITER_LOCK_EN is defined.
module rr_lock_arbiter
  import rr_lock_arbiter_pkg::*;
#(
  parameter int NumReq = 4,
  parameter int IdxW   = $clog2(NumReq)
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic [NumReq-1:0] REQ,
  input  logic [NumReq-1:0] LOCK,
  input  logic              RDY,
  output logic [NumReq-1:0] GNT,
  output logic              GNT_VLD,
  output logic [IdxW-1:0]   GNT_IDX
);

`ifdef RR_LOCK_ARBITER_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [NumReq-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              vld_q, vld_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic              arm_q;
  logic              upd_en, ptr_en;

  logic              xfer, owner_req, lock_take;
  logic [IdxW-1:0]   nxt_ptr;

  logic [NumReq-1:0] idle_oh, hand_oh;
  logic [IdxW-1:0]   idle_idx, hand_idx;
  logic              idle_found, hand_found;

  assign xfer      = vld_q & RDY;
  assign owner_req = |(REQ & gnt_q);
  assign lock_take = LockEn && (|(LOCK & gnt_q));
  assign nxt_ptr   = (idx_q == IdxW'(NumReq - 1)) ? '0 : idx_q + IdxW'(1);

  rr_pick #(.NumReq(NumReq), .IdxW(IdxW)) u_pick_idle (
    .req_i    (REQ),
    .mask_i   ({NumReq{1'b1}}),
    .ptr_i    (ptr_q),
    .onehot_o (idle_oh),
    .idx_o    (idle_idx),
    .found_o  (idle_found)
  );

  // Handoff search starts just past the owner and never re-selects it.
  rr_pick #(.NumReq(NumReq), .IdxW(IdxW)) u_pick_hand (
    .req_i    (REQ),
    .mask_i   (~gnt_q),
    .ptr_i    (nxt_ptr),
    .onehot_o (hand_oh),
    .idx_o    (hand_idx),
    .found_o  (hand_found)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    ptr_d   = ptr_q;
    upd_en  = 1'b0;
    ptr_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm_q && idle_found) begin
          upd_en  = 1'b1;
          gnt_d   = idle_oh;
          idx_d   = idle_idx;
          vld_d   = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY, ST_LOCKED: begin
        if (xfer && lock_take && owner_req) begin
          upd_en  = 1'b1;
          state_d = ST_LOCKED;
        end else if (xfer) begin
          upd_en = 1'b1;
          ptr_en = 1'b1;
          ptr_d  = nxt_ptr;
          if (hand_found) begin
            gnt_d   = hand_oh;
            idx_d   = hand_idx;
            vld_d   = 1'b1;
            state_d = ST_BUSY;
          end else begin
            gnt_d   = '0;
            idx_d   = '0;
            vld_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (!owner_req) begin
          upd_en  = 1'b1;
          gnt_d   = '0;
          idx_d   = '0;
          vld_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        upd_en  = 1'b1;
        gnt_d   = '0;
        idx_d   = '0;
        vld_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // arm_q holds off arbitration for the first edge after reset release.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      ptr_q   <= '0;
      arm_q   <= 1'b0;
    end else begin
      arm_q <= 1'b1;
      if (upd_en) begin
        state_q <= state_d;
        gnt_q   <= gnt_d;
        idx_q   <= idx_d;
        vld_q   <= vld_d;
      end
      if (ptr_en) begin
        ptr_q <= ptr_d;
      end
    end
  end

  assign GNT     = gnt_q;
  assign GNT_VLD = vld_q;
  assign GNT_IDX = idx_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Self-checking bench for rr_lock_arbiter (NumReq=4): directed scenarios with
// an expected-grant queue plus a randomized protocol/fairness checker.
module tb_rr_lock_arbiter;

  localparam int N = 4;
  localparam int W = 2;

  logic         CLK = 1'b0;
  logic         RSTN;
  logic [N-1:0] REQ;
  logic [N-1:0] LOCK;
  logic         RDY;
  logic [N-1:0] GNT;
  logic         GNT_VLD;
  logic [W-1:0] GNT_IDX;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  always #5 CLK = ~CLK;

  rr_lock_arbiter #(.NumReq(N), .IdxW(W)) dut (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .REQ     (REQ),
    .LOCK    (LOCK),
    .RDY     (RDY),
    .GNT     (GNT),
    .GNT_VLD (GNT_VLD),
    .GNT_IDX (GNT_IDX)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    REQ  = '0;
    LOCK = '0;
    RDY  = 1'b0;
    exp_q.delete();
    tick();
    tick();
    RSTN = 1'b1;
  endtask

  function automatic logic [N-1:0] onehot(input int k);
    return N'(1) << k;
  endfunction

  task automatic test_reset();
    RSTN = 1'b0;
    REQ  = '1;
    LOCK = '0;
    RDY  = 1'b1;
    #3;
    n_tests++; if (GNT !== '0) begin n_fail++; $display("FAIL rst_gnt: got %b expected %b", GNT, 4'b0); end
    n_tests++; if (GNT_VLD !== 1'b0) begin n_fail++; $display("FAIL rst_vld: got %b expected 0", GNT_VLD); end
    n_tests++; if (GNT_IDX !== '0) begin n_fail++; $display("FAIL rst_idx: got %0d expected 0", GNT_IDX); end
    tick();
    tick();
    n_tests++; if (GNT !== '0) begin n_fail++; $display("FAIL rst_hold_gnt: got %b expected 0000", GNT); end
    RSTN = 1'b1;
    tick();
    n_tests++; if (GNT_VLD !== 1'b0) begin n_fail++; $display("FAIL rst_first_edge: got vld %b expected 0", GNT_VLD); end
    tick();
    n_tests++; if (GNT_VLD !== 1'b1 || GNT_IDX !== 2'd0) begin
      n_fail++; $display("FAIL rst_second_edge: got vld %b idx %0d expected vld 1 idx 0", GNT_VLD, GNT_IDX);
    end
  endtask

  task automatic test_single_hold();
    int e;
    do_reset();
    REQ = 4'b0100;
    tick();
    n_tests++; if (GNT !== 4'b0000) begin n_fail++; $display("FAIL single_arm: got %b expected 0000", GNT); end
    tick();
    n_tests++; if (GNT !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b expected 0100", GNT); end
    tick();
    tick();
    n_tests++; if (GNT !== 4'b0100 || GNT_IDX !== 2'd2) begin
      n_fail++; $display("FAIL single_hold: got %b idx %0d expected 0100 idx 2", GNT, GNT_IDX);
    end
    RDY = 1'b1;
    exp_q.push_back(2);
    if (GNT_VLD && RDY) begin
      e = exp_q.pop_front();
      n_tests++; if (GNT_IDX !== W'(e)) begin n_fail++; $display("FAIL single_xfer: got %0d expected %0d", GNT_IDX, e); end
    end
    tick();
    n_tests++; if (GNT_VLD !== 1'b0 || GNT !== '0) begin
      n_fail++; $display("FAIL single_idle: got vld %b gnt %b expected 0 0000", GNT_VLD, GNT);
    end
    REQ = 4'b1111;
    RDY = 1'b0;
    tick();
    n_tests++; if (GNT_IDX !== 2'd3 || GNT !== 4'b1000) begin
      n_fail++; $display("FAIL single_ptr: got idx %0d gnt %b expected 3 1000", GNT_IDX, GNT);
    end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_drain: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_rotation();
    int e;
    do_reset();
    REQ = 4'b1111;
    RDY = 1'b1;
    for (int k = 0; k < 8; k++) exp_q.push_back(k % N);
    tick();
    tick();
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if (GNT_VLD !== 1'b1) begin
        n_fail++; $display("FAIL rot_bubble: cycle %0d got vld %b expected 1", k, GNT_VLD);
      end else begin
        e = exp_q.pop_front();
        n_tests++; if (GNT_IDX !== W'(e) || GNT !== onehot(e)) begin
          n_fail++; $display("FAIL rot_order: cycle %0d got idx %0d gnt %b expected %0d", k, GNT_IDX, GNT, e);
        end
      end
      tick();
    end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rot_drain: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_lock();
    int lk_exp[5];
    int xf;
    int e;
`ifdef RR_LOCK_ARBITER_LOCK_EN
    lk_exp = '{1, 1, 1, 1, 3};
`else
    lk_exp = '{1, 3, 0, 1, 3};
`endif
    do_reset();
    REQ = 4'b0010;
    tick();
    tick();
    n_tests++; if (GNT !== 4'b0010) begin n_fail++; $display("FAIL lock_setup: got %b expected 0010", GNT); end
    REQ  = 4'b1011;
    LOCK = 4'b0010;
    RDY  = 1'b1;
    foreach (lk_exp[i]) exp_q.push_back(lk_exp[i]);
    xf = 0;
    for (int c = 0; c < 40 && xf < 5; c++) begin
      if (GNT_VLD && RDY) begin
        e = exp_q.pop_front();
        n_tests++; if (GNT_IDX !== W'(e)) begin
          n_fail++; $display("FAIL lock_seq: transfer %0d got %0d expected %0d", xf, GNT_IDX, e);
        end
        xf++;
      end
      tick();
      if (xf >= 3) LOCK = '0;
    end
    n_tests++; if (xf != 5) begin n_fail++; $display("FAIL lock_budget: got %0d transfers expected 5", xf); end
  endtask

  task automatic test_abort();
    do_reset();
    REQ = 4'b0010;
    RDY = 1'b1;
    tick();
    tick();
    n_tests++; if (GNT !== 4'b0010) begin n_fail++; $display("FAIL abort_setup: got %b expected 0010", GNT); end
    tick();
    REQ = 4'b0100;
    RDY = 1'b0;
    tick();
    n_tests++; if (GNT !== 4'b0100) begin n_fail++; $display("FAIL abort_own: got %b expected 0100", GNT); end
    REQ = 4'b0111;
    tick();
    n_tests++; if (GNT !== 4'b0100) begin n_fail++; $display("FAIL abort_other1: got %b expected 0100", GNT); end
    REQ = 4'b1101;
    tick();
    n_tests++; if (GNT !== 4'b0100) begin n_fail++; $display("FAIL abort_other2: got %b expected 0100", GNT); end
    REQ = 4'b0000;
    tick();
    n_tests++; if (GNT !== '0 || GNT_VLD !== 1'b0 || GNT_IDX !== '0) begin
      n_fail++; $display("FAIL abort_clear: got %b vld %b idx %0d expected 0000 0 0", GNT, GNT_VLD, GNT_IDX);
    end
    REQ = 4'b1111;
    tick();
    n_tests++; if (GNT_IDX !== 2'd2 || GNT_VLD !== 1'b1) begin
      n_fail++; $display("FAIL abort_ptr: got idx %0d vld %b expected 2 1", GNT_IDX, GNT_VLD);
    end
  endtask

  task automatic test_reset_locked();
    do_reset();
    REQ  = 4'b0100;
    LOCK = 4'b0100;
    RDY  = 1'b1;
    tick();
    tick();
    n_tests++; if (GNT !== 4'b0100) begin n_fail++; $display("FAIL rl_pre: got %b expected 0100", GNT); end
`ifdef RR_LOCK_ARBITER_LOCK_EN
    tick();
    n_tests++; if (GNT !== 4'b0100) begin n_fail++; $display("FAIL rl_locked: got %b expected 0100", GNT); end
`endif
    #2;
    RSTN = 1'b0;
    #1;
    n_tests++; if (GNT !== '0 || GNT_VLD !== 1'b0 || GNT_IDX !== '0) begin
      n_fail++; $display("FAIL rl_async: got %b vld %b idx %0d expected 0000 0 0", GNT, GNT_VLD, GNT_IDX);
    end
    REQ  = 4'b1111;
    LOCK = '0;
    RDY  = 1'b0;
    RSTN = 1'b1;
    tick();
    tick();
    n_tests++; if (GNT_VLD !== 1'b1 || GNT_IDX !== 2'd0) begin
      n_fail++; $display("FAIL rl_first: got vld %b idx %0d expected 1 0", GNT_VLD, GNT_IDX);
    end
  endtask

  task automatic test_random();
    int           wt[N];
    logic [N-1:0] drop;
    logic [N-1:0] dropped;
    do_reset();
    drop = '0;
    foreach (wt[i]) wt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      tick();
      n_tests++; if ($countones(GNT) > 1) begin n_fail++; $display("FAIL rnd_onehot: cycle %0d got %b", c, GNT); end
      n_tests++; if (GNT_VLD !== (|GNT)) begin n_fail++; $display("FAIL rnd_vld: cycle %0d got %b expected %b", c, GNT_VLD, |GNT); end
      n_tests++;
      if (GNT_VLD && GNT !== onehot(int'(GNT_IDX))) begin
        n_fail++; $display("FAIL rnd_idx: cycle %0d got idx %0d gnt %b", c, GNT_IDX, GNT);
      end else if (!GNT_VLD && GNT_IDX !== '0) begin
        n_fail++; $display("FAIL rnd_idx0: cycle %0d got %0d expected 0", c, GNT_IDX);
      end
      if (GNT_VLD) begin
        n_tests++; if ((GNT & REQ) !== GNT) begin n_fail++; $display("FAIL rnd_owner_req: cycle %0d got gnt %b req %b", c, GNT, REQ); end
      end
      dropped = drop;
      REQ     = REQ & ~drop;
      drop    = '0;
      for (int i = 0; i < N; i++) begin
        if (!REQ[i] && !dropped[i] && $urandom_range(0, 3) == 0) begin
          REQ[i] = 1'b1;
          wt[i]  = 0;
        end
      end
      RDY = 1'($urandom_range(0, 1));
      if (GNT_VLD && RDY) begin
        drop = GNT;
        for (int i = 0; i < N; i++) begin
          if (GNT[i]) begin
            wt[i] = 0;
          end else if (REQ[i]) begin
            wt[i]++;
            n_tests++; if (wt[i] > N) begin n_fail++; $display("FAIL rnd_fair: req %0d waited %0d transfers, limit %0d", i, wt[i], N); end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_hold();
    test_rotation();
    test_lock();
    test_abort();
    test_reset_locked();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
